// File: rtl/div_share_arbiter.sv
// Shares one sequential sign-magnitude Q8.7 divider among NUM_REQ requesters.
// Requests are granted round-robin, and each answer goes back on one id-tagged response channel.
module div_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [16*NUM_REQ-1:0] req_dividend,
  input  logic [16*NUM_REQ-1:0] req_divisor,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [15:0]           rsp_quotient,
  output logic [3:0]            rsp_flags,
  output logic [15:0]           div_dividend,
  output logic [15:0]           div_divisor,
  output logic                  div_enable,
  input  logic [15:0]           div_quotient,
  input  logic                  div_overflow,
  input  logic                  div_error,
  input  logic                  div_finished
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_WAIT, ST_RESP} state_t;

  state_t            r_state, w_state_nxt;
  logic [ID_W-1:0]   r_rr_ptr, r_rsp_id;
  logic [15:0]       r_div_a, r_div_b, r_quot;
  logic [3:0]        r_flags;
  logic [CNT_W-1:0]  r_cnt;

  logic [NUM_REQ-1:0] w_grant;
  logic               w_found;
  logic [ID_W-1:0]    w_gid, w_idx;
  logic [15:0]        w_sel_a, w_sel_b;
  logic               w_zero, w_done, w_tmo;

  // Round-robin search starting at r_rr_ptr.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_grant = '0;
    w_found = 1'b0;
    w_gid   = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
      if (!w_found && req_valid[w_idx]) begin
        w_found        = 1'b1;
        w_grant[w_idx] = 1'b1;
        w_gid          = w_idx;
      end
    end
  end

  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_a = req_dividend[16*i +: 16];
        w_sel_b = req_divisor[16*i +: 16];
      end
    end
  end

  // The sign bit is ignored, so negative zero also short-circuits.
  assign w_zero = (w_sel_b[14:0] == 15'd0);
  // Finished is stale in the first WAIT cycle while the divider clears it.
  assign w_done = (r_cnt != '0) && div_finished;
  assign w_tmo  = (r_cnt == CNT_W'(TIMEOUT - 1));

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    div_enable  = 1'b0;
    rsp_valid   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = rst ? '0 : w_grant;
        if (w_found) w_state_nxt = w_zero ? ST_RESP : ST_LOAD;
      end
      ST_LOAD: begin
        div_enable  = 1'b1;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (w_done || w_tmo) w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
      r_rsp_id <= '0;
      r_div_a  <= '0;
      r_div_b  <= '0;
      r_quot   <= '0;
      r_flags  <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_div_a  <= w_sel_a;
            r_div_b  <= w_sel_b;
            r_rsp_id <= w_gid;
            r_rr_ptr <= ID_W'((int'(w_gid) + 1) % NUM_REQ);
            if (w_zero) begin
              r_quot  <= '0;
              r_flags <= 4'b0110;
            end
          end
        end
        ST_LOAD: r_cnt <= '0;
        ST_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_done) begin
            r_quot  <= div_quotient;
            r_flags <= {2'b00, div_overflow, div_error};
          end else if (w_tmo) begin
            r_quot  <= '0;
            r_flags <= 4'b1001;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_id       = r_rsp_id;
  assign rsp_quotient = r_quot;
  assign rsp_flags    = r_flags;
  assign div_dividend = r_div_a;
  assign div_divisor  = r_div_b;

endmodule

// File: tb/tb_div_share_arbiter.sv
// Directed bench for div_share_arbiter with a small stub divider.
// The stub finishes after a few cycles, or never when hang is set.
module tb_div_share_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int TIMEOUT = 8;
  localparam int LAT     = 4;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [NUM_REQ-1:0]    req_ready;
  logic [16*NUM_REQ-1:0] req_dividend = '0;
  logic [16*NUM_REQ-1:0] req_divisor = '0;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b1;
  logic [ID_W-1:0]       rsp_id;
  logic [15:0]           rsp_quotient;
  logic [3:0]            rsp_flags;
  logic [15:0]           div_dividend, div_divisor;
  logic                  div_enable;
  logic [15:0]           div_quotient = '0;
  logic                  div_overflow = 1'b0;
  logic                  div_error = 1'b0;
  logic                  div_finished = 1'b0;

  div_share_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_quotient(rsp_quotient), .rsp_flags(rsp_flags),
    .div_dividend(div_dividend), .div_divisor(div_divisor), .div_enable(div_enable),
    .div_quotient(div_quotient), .div_overflow(div_overflow),
    .div_error(div_error), .div_finished(div_finished)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_fail = 0;
  int n_en = 0;
  bit multi_hot = 1'b0;
  bit hang = 1'b0;
  int grant_q[$];

  // Stub divider: finished stays stale for one cycle after enable, then clears.
  logic [15:0] s_a = '0, s_b = '0;
  int          s_cnt = 0;
  bit          s_busy = 1'b0;

  function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b);
    logic [21:0] q;
    q = {a[14:0], 7'b0} / {7'b0, b[14:0]};
    if (q > 22'h7FFF) return {1'b1, a[15] ^ b[15], 15'h7FFF};
    return {1'b0, a[15] ^ b[15], q[14:0]};
  endfunction

  always @(posedge clk) begin
    if (div_enable) begin
      s_a    <= div_dividend;
      s_b    <= div_divisor;
      s_busy <= 1'b1;
      s_cnt  <= LAT;
    end else if (s_busy) begin
      if (s_cnt == LAT) div_finished <= 1'b0;
      if (s_cnt == 1) begin
        s_busy <= 1'b0;
        if (!hang) begin
          div_finished <= 1'b1;
          {div_overflow, div_quotient} <= model(s_a, s_b);
        end
      end
      s_cnt <= s_cnt - 1;
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      if (div_enable) n_en <= n_en + 1;
      if ($countones(req_ready) > 1) multi_hot <= 1'b1;
      for (int i = 0; i < NUM_REQ; i++)
        if (req_valid[i] && req_ready[i]) grant_q.push_back(i);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge following the handshake edge.
  task automatic do_req(input int id, input logic [15:0] a, input logic [15:0] b);
    int n;
    n = 0;
    req_dividend[16*id +: 16] = a;
    req_divisor[16*id +: 16]  = b;
    req_valid[id] = 1'b1;
    #1;
    while (req_ready[id] !== 1'b1 && n < 100) begin
      @(negedge clk); #1; n++;
    end
    check($sformatf("grant_req%0d", id), {31'b0, req_ready[id]}, 32'd1);
    @(negedge clk);
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 100) begin
      @(negedge clk); n++;
    end
  endtask

  int n, en0, bad;
  int exp_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    // Reset with every requester already valid.
    for (int i = 0; i < NUM_REQ; i++) begin
      req_dividend[16*i +: 16] = 16'h0100;
      req_divisor[16*i +: 16]  = 16'h0100;
    end
    req_valid = '1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_quotient", rsp_quotient, 0);
    check("rst_rsp_flags", rsp_flags, 0);
    check("rst_div_enable", div_enable, 0);
    check("rst_div_dividend", div_dividend, 0);
    check("rst_div_divisor", div_divisor, 0);

    // Round-robin fairness with all requesters continuously valid.
    rst = 1'b0;
    n = 0;
    while (grant_q.size() < 5 && n < 400) begin
      @(negedge clk); n++;
    end
    req_valid = '0;
    check("fair_grant_count", grant_q.size(), 5);
    for (int i = 0; i < 5; i++)
      check($sformatf("fair_grant%0d", i), (i < grant_q.size()) ? grant_q[i] : -1, exp_order[i]);
    repeat (20) @(negedge clk);

    // 6.0 / 2.0 from requester 1.
    en0 = n_en;
    do_req(1, 16'h0300, 16'h0100);
    wait_rsp(n);
    check("t1_rsp_valid", rsp_valid, 1);
    check("t1_rsp_id", rsp_id, 1);
    check("t1_quotient", rsp_quotient, 16'h0180);
    check("t1_flags", rsp_flags, 4'b0000);
    @(negedge clk);
    check("t1_rsp_drop", rsp_valid, 0);
    check("t1_enable_pulses", n_en - en0, 1);

    // -6.0 / 2.0 from requester 2.
    do_req(2, 16'h8300, 16'h0100);
    wait_rsp(n);
    check("t2_rsp_valid", rsp_valid, 1);
    check("t2_rsp_id", rsp_id, 2);
    check("t2_quotient", rsp_quotient, 16'h8180);
    check("t2_flags", rsp_flags, 4'b0000);
    @(negedge clk);

    // Overflowing divide from requester 3: overflow flag lands in bit 1.
    do_req(3, 16'h7F00, 16'h0001);
    wait_rsp(n);
    check("t3_rsp_id", rsp_id, 3);
    check("t3_quotient", rsp_quotient, 16'h7FFF);
    check("t3_flags", rsp_flags, 4'b0010);
    @(negedge clk);

    // Negative-zero divisor from requester 0: no divider start.
    en0 = n_en;
    do_req(0, 16'h0300, 16'h8000);
    wait_rsp(n);
    check("dz_latency_ok", n <= 2, 1);
    check("dz_rsp_id", rsp_id, 0);
    check("dz_quotient", rsp_quotient, 0);
    check("dz_flags", rsp_flags, 4'b0110);
    @(negedge clk);
    check("dz_enable_pulses", n_en - en0, 0);

    // Response stall: rsp_ready low for 10 cycles while others request.
    rsp_ready = 1'b0;
    do_req(1, 16'h0400, 16'h0200);
    req_valid[0] = 1'b1;
    req_valid[2] = 1'b1;
    req_valid[3] = 1'b1;
    wait_rsp(n);
    check("stall_rsp_valid", rsp_valid, 1);
    check("stall_quotient", rsp_quotient, 16'h0100);
    bad = 0;
    repeat (10) begin
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_quotient !== 16'h0100 ||
          rsp_flags !== 4'b0000 || req_ready !== 4'b0000) bad++;
      @(negedge clk);
    end
    check("stall_stable_cycles_bad", bad, 0);
    req_valid = '0;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("stall_release", rsp_valid, 0);

    // Divider that never finishes: timeout after TIMEOUT WAIT cycles.
    hang = 1'b1;
    do_req(2, 16'h0100, 16'h0100);
    wait_rsp(n);
    check("tmo_latency", n, 9);
    check("tmo_rsp_id", rsp_id, 2);
    check("tmo_quotient", rsp_quotient, 0);
    check("tmo_flags", rsp_flags, 4'b1001);
    @(negedge clk);
    hang = 1'b0;

    // Reset during WAIT; the stub's finished arrives afterwards.
    do_req(3, 16'h0300, 16'h0100);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_div_enable", div_enable, 0);
    check("rst_mid_rsp_id", rsp_id, 0);
    rst = 1'b0;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || div_enable !== 1'b0 || req_ready !== 4'b0000) bad++;
    end
    check("rst_mid_quiet_bad", bad, 0);
    do_req(0, 16'h0300, 16'h0100);
    wait_rsp(n);
    check("rst_mid_next_id", rsp_id, 0);
    check("rst_mid_next_quotient", rsp_quotient, 16'h0180);
    check("rst_mid_next_flags", rsp_flags, 4'b0000);
    @(negedge clk);

    check("req_ready_multi_hot", multi_hot, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
